// File: rtl/ddr_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ddr_tx_serializer
// Description : DDR-mode SDA bit serializer driven by SCL edge strobes.
//               Optional CRC5 generation is enabled with `define DDR_TX_CRC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_tx_serializer (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_tx_en,
  input  logic [3:0] i_tx_mode,
  input  logic [7:0] i_tx_byte,
  input  logic       i_sclgen_pos_edge,
  input  logic       i_sclgen_neg_edge,
  output logic       o_sda,
  output logic       o_sda_pp_od,
  output logic       o_tx_mode_done
);

  localparam logic [3:0] MODE_CMD_PRE   = 4'd0;
  localparam logic [3:0] MODE_ONE       = 4'd1;
  localparam logic [3:0] MODE_BYTE      = 4'd2;
  localparam logic [3:0] MODE_PARITY    = 4'd3;
  localparam logic [3:0] MODE_ZERO      = 4'd4;
  localparam logic [3:0] MODE_CRC_TOKEN = 4'd5;
  localparam logic [3:0] MODE_CRC5      = 4'd6;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  mode, mode_nx;
  logic [7:0]  tx_byte, tx_byte_nx;
  logic [2:0]  idx, idx_nx;
  logic [1:0]  parity, parity_nx;
  logic [15:0] word, word_nx;
  logic        sda_nx, pp_od_nx, done_nx;

  logic        slot, fire, start, bit_val;
  logic [3:0]  cur_mode;
  logic [2:0]  bit_idx, last_idx;
  logic [7:0]  byte_sh;
  logic [1:0]  pa_now, par_sh;
`ifdef DDR_TX_CRC_EN
  logic [4:0]  crc, crc_nx, crc_lat, crc_lat_nx, crc_sh;
  logic        crc_fb;
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state          <= IDLE;
      mode           <= 4'd0;
      tx_byte        <= 8'd0;
      idx            <= 3'd0;
      parity         <= 2'd0;
      word           <= 16'd0;
      o_sda          <= 1'b1;
      o_sda_pp_od    <= 1'b0;
      o_tx_mode_done <= 1'b0;
`ifdef DDR_TX_CRC_EN
      crc            <= 5'h1F;
      crc_lat        <= 5'h1F;
`endif
    end else begin
      state          <= state_nx;
      mode           <= mode_nx;
      tx_byte        <= tx_byte_nx;
      idx            <= idx_nx;
      parity         <= parity_nx;
      word           <= word_nx;
      o_sda          <= sda_nx;
      o_sda_pp_od    <= pp_od_nx;
      o_tx_mode_done <= done_nx;
`ifdef DDR_TX_CRC_EN
      crc            <= crc_nx;
      crc_lat        <= crc_lat_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    mode_nx    = mode;
    tx_byte_nx = tx_byte;
    idx_nx     = idx;
    parity_nx  = parity;
    word_nx    = word;
    sda_nx     = o_sda;
    pp_od_nx   = o_sda_pp_od;
    done_nx    = 1'b0;

    // idx==0 while ACTIVE means the previous mode finished; the next slot starts a new one
    slot     = i_sclgen_pos_edge | i_sclgen_neg_edge;
    fire     = slot & i_tx_en;
    start    = (state == IDLE) || (idx == 3'd0);
    cur_mode = start ? i_tx_mode : mode;
    bit_idx  = start ? 3'd0 : idx;
    byte_sh  = (start ? i_tx_byte : tx_byte) << bit_idx;
    pa_now   = {^(word & 16'hAAAA), ~^(word & 16'h5555)};
    par_sh   = (start ? pa_now : parity) << bit_idx[0];
`ifdef DDR_TX_CRC_EN
    crc_nx     = crc;
    crc_lat_nx = crc_lat;
    crc_sh     = (start ? crc : crc_lat) << bit_idx;
`endif

    bit_val  = 1'b1;
    last_idx = 3'd0;
    case (cur_mode)
      MODE_CMD_PRE:   begin bit_val = (bit_idx != 3'd0); last_idx = 3'd1; end
      MODE_ONE:       begin bit_val = 1'b1;              last_idx = 3'd0; end
      MODE_BYTE:      begin bit_val = byte_sh[7];        last_idx = 3'd7; end
      MODE_PARITY:    begin bit_val = par_sh[1];         last_idx = 3'd1; end
      MODE_ZERO:      begin bit_val = 1'b0;              last_idx = 3'd0; end
      MODE_CRC_TOKEN: begin bit_val = (bit_idx < 3'd2);  last_idx = 3'd3; end
      MODE_CRC5: begin
`ifdef DDR_TX_CRC_EN
        bit_val  = crc_sh[4];
`else
        bit_val  = 1'b1;
`endif
        last_idx = 3'd4;
      end
      default:        begin bit_val = 1'b1;              last_idx = 3'd0; end
    endcase

`ifdef DDR_TX_CRC_EN
    crc_fb = crc[4] ^ bit_val;
`endif

    if (state == ACTIVE && !i_tx_en) begin
      state_nx = IDLE;
      idx_nx   = 3'd0;
      sda_nx   = 1'b1;
      pp_od_nx = 1'b0;
    end else if (fire) begin
      state_nx = ACTIVE;
      sda_nx   = bit_val;
      pp_od_nx = 1'b1;
      if (start) begin
        mode_nx    = i_tx_mode;
        tx_byte_nx = i_tx_byte;
        parity_nx  = pa_now;
`ifdef DDR_TX_CRC_EN
        crc_lat_nx = crc;
`endif
      end
      if (bit_idx == last_idx) begin
        idx_nx  = 3'd0;
        done_nx = 1'b1;
      end else begin
        idx_nx  = bit_idx + 3'd1;
      end
      if (cur_mode == MODE_BYTE) begin
        word_nx = {word[14:0], bit_val};
`ifdef DDR_TX_CRC_EN
        crc_nx  = {crc[3:0], 1'b0} ^ (crc_fb ? 5'b00101 : 5'b00000);
`endif
      end
      if (cur_mode == MODE_PARITY && bit_idx == last_idx) begin
        word_nx = 16'd0;
      end
`ifdef DDR_TX_CRC_EN
      if (cur_mode == MODE_CMD_PRE && start) begin
        crc_nx = 5'h1F;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_tx_serializer
// Description : Self-checking bench for ddr_tx_serializer with a mode-level
//               reference model; honours `define DDR_TX_CRC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_tx_serializer;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       tx_en   = 1'b0;
  logic [3:0] tx_mode = 4'd0;
  logic [7:0] tx_byte = 8'd0;
  logic       pos     = 1'b0;
  logic       neg     = 1'b0;
  logic       sda, pp_od, done;

  always #5 sys_clk = ~sys_clk;

  ddr_tx_serializer dut (
    .i_sys_clk        (sys_clk),
    .i_sys_rst        (sys_rst),
    .i_tx_en          (tx_en),
    .i_tx_mode        (tx_mode),
    .i_tx_byte        (tx_byte),
    .i_sclgen_pos_edge(pos),
    .i_sclgen_neg_edge(neg),
    .o_sda            (sda),
    .o_sda_pp_od      (pp_od),
    .o_tx_mode_done   (done)
  );

  typedef struct {
    logic       b;
    logic       last;
    logic       first;
    logic [3:0] md;
    logic [7:0] by;
  } slot_t;

  slot_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        both_strobes = 1'b0;
  logic [15:0] m_word;
  logic [4:0]  m_crc;

  // Expected bit stream of one mode, MSB of 'bits' first
  task automatic exp_push(input logic [3:0] md, input logic [7:0] by,
                          input logic [31:0] bits, input int n);
    slot_t s;
    for (int i = 0; i < n; i++) begin
      s.b     = bits[n-1-i];
      s.last  = (i == n - 1);
      s.first = (i == 0);
      s.md    = md;
      s.by    = by;
      exp_q.push_back(s);
    end
  endtask

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic d);
    int v;
    v = (int'(c) * 2) ^ (((c[4] ^ d) == 1'b1) ? 5 : 0);
    return 5'(v);
  endfunction

  task automatic model_mode(input logic [3:0] md, input logic [7:0] by);
    logic pa1, pa0;
    case (md)
      4'd0: begin m_crc = 5'h1F; exp_push(md, by, 32'b01, 2); end
      4'd1: exp_push(md, by, 32'b1, 1);
      4'd2: begin
        for (int i = 7; i >= 0; i--) m_crc = crc5_step(m_crc, by[i]);
        m_word = {m_word[7:0], by};
        exp_push(md, by, {24'd0, by}, 8);
      end
      4'd3: begin
        pa1 = ^(m_word & 16'hAAAA);
        pa0 = (^(m_word & 16'h5555)) ^ 1'b1;
        exp_push(md, by, {30'd0, pa1, pa0}, 2);
        m_word = 16'd0;
      end
      4'd4: exp_push(md, by, 32'b0, 1);
      4'd5: exp_push(md, by, 32'b1100, 4);
`ifdef DDR_TX_CRC_EN
      4'd6: exp_push(md, by, {27'd0, m_crc}, 5);
`else
      4'd6: exp_push(md, by, 32'b11111, 5);
`endif
      default: exp_push(md, by, 32'b1, 1);
    endcase
  endtask

  // One-cycle strobe issued from a negedge; returns at the following negedge
  task automatic strobe(input logic [3:0] md, input logic [7:0] by);
    int kind;
    kind    = both_strobes ? 2 : $urandom_range(0, 2);
    pos     = (kind != 1);
    neg     = (kind != 0);
    tx_mode = md;
    tx_byte = by;
    @(negedge sys_clk);
    pos     = 1'b0;
    neg     = 1'b0;
    tx_mode = 4'($urandom);
    tx_byte = 8'($urandom);
  endtask

  task automatic play_stream(input string tag);
    slot_t s;
    int    gap;
    tx_en = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      s = exp_q[i];
      if (s.first) strobe(s.md, s.by);
      else         strobe(4'($urandom), 8'($urandom));
      tests++;
      if (sda !== s.b || done !== s.last || pp_od !== 1'b1) begin
        fails++;
        $display("FAIL %s slot %0d: sda/done/pp_od got %b%b%b expected %b%b1",
                 tag, i, sda, done, pp_od, s.b, s.last);
      end
      gap = (i == exp_q.size() - 1) ? 0 : $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge sys_clk);
        tests++;
        if (sda !== s.b || done !== 1'b0 || pp_od !== 1'b1) begin
          fails++;
          $display("FAIL %s hold after slot %0d: sda/done/pp_od got %b%b%b expected %b01",
                   tag, i, sda, done, pp_od, s.b);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic drop_en_check_idle(input string tag);
    tx_en = 1'b0;
    @(negedge sys_clk);
    tests++;
    if ({sda, pp_od, done} !== 3'b100) begin
      fails++;
      $display("FAIL %s idle: sda/pp_od/done got %b%b%b expected 100", tag, sda, pp_od, done);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    tests++;
    if ({sda, pp_od, done} !== 3'b100) begin
      fails++;
      $display("FAIL reset: sda/pp_od/done got %b%b%b expected 100", sda, pp_od, done);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    tests++;
    if ({sda, pp_od, done} !== 3'b100) begin
      fails++;
      $display("FAIL reset_release: sda/pp_od/done got %b%b%b expected 100", sda, pp_od, done);
    end
  endtask

  task automatic test_idle_ignore();
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(4'd4, 8'h00);
      tests++;
      if ({sda, pp_od, done} !== 3'b100) begin
        fails++;
        $display("FAIL idle_ignore %0d: sda/pp_od/done got %b%b%b expected 100", i, sda, pp_od, done);
      end
    end
  endtask

  task automatic test_byte_a5();
    exp_push(4'd2, 8'hA5, 32'hA5, 8);
    play_stream("byte_a5");
    drop_en_check_idle("byte_a5_done");
    strobe(4'd4, 8'h00);
    tests++;
    if ({sda, pp_od, done} !== 3'b100) begin
      fails++;
      $display("FAIL after_done_ignore: sda/pp_od/done got %b%b%b expected 100", sda, pp_od, done);
    end
  endtask

  task automatic test_parity_seq();
    exp_push(4'd0, 8'h00, 32'b01, 2);
    exp_push(4'd2, 8'h80, 32'h80, 8);
    exp_push(4'd2, 8'h01, 32'h01, 8);
    exp_push(4'd3, 8'h00, 32'b10, 2);
    play_stream("parity_seq");
    drop_en_check_idle("parity_seq_end");
  endtask

  task automatic test_crc();
    exp_push(4'd0, 8'h00, 32'b01, 2);
    exp_push(4'd2, 8'h00, 32'h00, 8);
    exp_push(4'd5, 8'h00, 32'b1100, 4);
`ifdef DDR_TX_CRC_EN
    exp_push(4'd6, 8'h00, 32'b01111, 5);
`else
    exp_push(4'd6, 8'h00, 32'b11111, 5);
`endif
    play_stream("crc");
    drop_en_check_idle("crc_end");
  endtask

  task automatic test_abort();
    tx_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) strobe(4'd2, 8'hFF);
      else        strobe(4'($urandom), 8'($urandom));
      tests++;
      if ({sda, pp_od, done} !== 3'b110) begin
        fails++;
        $display("FAIL abort bit %0d: sda/pp_od/done got %b%b%b expected 110", i, sda, pp_od, done);
      end
    end
    drop_en_check_idle("abort");
    @(negedge sys_clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_done: done got %b expected 0", done);
    end
    tx_en = 1'b1;
    strobe(4'd4, 8'hFF);
    tests++;
    if ({sda, pp_od, done} !== 3'b011) begin
      fails++;
      $display("FAIL abort_restart: sda/pp_od/done got %b%b%b expected 011", sda, pp_od, done);
    end
    drop_en_check_idle("abort_restart_end");
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h3C;
    tx_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) strobe(4'd2, 8'h3C);
      else        strobe(4'($urandom), 8'($urandom));
      tests++;
      if (sda !== b[7-i] || done !== 1'b0 || pp_od !== 1'b1) begin
        fails++;
        $display("FAIL rst_mid bit %0d: sda/done/pp_od got %b%b%b expected %b01", i, sda, done, pp_od, b[7-i]);
      end
    end
    #2 sys_rst = 1'b0;
    #1;
    tests++;
    if ({sda, pp_od, done} !== 3'b100) begin
      fails++;
      $display("FAIL rst_mid_immediate: sda/pp_od/done got %b%b%b expected 100", sda, pp_od, done);
    end
    @(negedge sys_clk);
    tests++;
    if ({sda, pp_od, done} !== 3'b100) begin
      fails++;
      $display("FAIL rst_mid_held: sda/pp_od/done got %b%b%b expected 100", sda, pp_od, done);
    end
    sys_rst = 1'b1;
    tx_en   = 1'b0;
    @(negedge sys_clk);
    exp_push(4'd3, 8'h00, 32'b01, 2);
    exp_push(4'd6, 8'h00, 32'b11111, 5);
    play_stream("post_reset");
    drop_en_check_idle("post_reset_end");
  endtask

  task automatic test_dual_strobe();
    both_strobes = 1'b1;
    exp_push(4'd1, 8'h00, 32'b1, 1);
    exp_push(4'd4, 8'h00, 32'b0, 1);
    exp_push(4'd0, 8'h00, 32'b01, 2);
    play_stream("dual_strobe");
    both_strobes = 1'b0;
    drop_en_check_idle("dual_strobe_end");
  endtask

  task automatic test_random();
    logic [3:0] md;
    m_word = 16'd0;
    m_crc  = 5'h1F;
    for (int i = 0; i < 40; i++) begin
      md = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      model_mode(md, 8'($urandom));
    end
    play_stream("random");
    drop_en_check_idle("random_end");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_byte_a5();
    test_parity_seq();
    test_crc();
    test_abort();
    test_reset_mid();
    test_dual_strobe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_tx_serializer.md
DDR_TX_SERIALIZER -- requirements
Module: ddr_tx_serializer

Interface
REQ-001 Parameter: none; all widths are fixed.
REQ-002 i_sys_clk  in  1  system clock; all state updates on its rising edge.
REQ-003 i_sys_rst  in  1  asynchronous, active-low reset.
REQ-004 i_tx_en  in  1  serializer enable from the CCC handler.
REQ-005 i_tx_mode  in  4  mode code: 0 CMD_PRE, 1 ONE, 2 BYTE, 3 PARITY, 4 ZERO, 5 CRC_TOKEN, 6 CRC5; 7-15 reserved.
REQ-006 i_tx_byte  in  8  byte to send in BYTE mode, MSB first.
REQ-007 i_sclgen_pos_edge / i_sclgen_neg_edge  in  1 each  single-cycle SCL edge strobes; either one is a bit slot.
REQ-008 o_sda  out  1  serial data to the SDA handler.
REQ-009 o_sda_pp_od  out  1  1 = push-pull; high while a mode is active.
REQ-010 o_tx_mode_done  out  1  single-cycle pulse when the last bit of a mode is launched.

Function
REQ-011 The FSM SHALL have two states: IDLE and ACTIVE.
REQ-012 IDLE -> ACTIVE SHALL occur on the first edge strobe with i_tx_en=1. That strobe latches i_tx_mode and i_tx_byte and launches bit 0.
REQ-013 o_sda SHALL be registered. Each bit SHALL appear the cycle after its launching strobe and hold until the next strobe.
REQ-014 Bit counts and values per mode SHALL be:
- CMD_PRE: 0,1
- ONE: 1
- ZERO: 0
- BYTE: i_tx_byte[7..0]
- PARITY: PA1,PA0
- CRC_TOKEN: 1,1,0,0
- CRC5: crc[4..0]
REQ-015 Reserved modes SHALL send a single 1.
REQ-016 o_tx_mode_done SHALL assert in the cycle the last bit of the mode appears on o_sda.
REQ-017 If i_tx_en=1 after done, the next strobe SHALL latch the new mode and byte and launch its bit 0. There are no gap slots.
REQ-018 If i_tx_en=0 at done, the FSM SHALL return to IDLE with o_sda=1 and o_sda_pp_od=0.
REQ-019 Deasserting i_tx_en mid-mode SHALL abort the mode: IDLE on the next clock, o_sda=1, no done pulse.
REQ-020 If pos and neg strobes occur in the same cycle, they SHALL count as one slot.
REQ-021 In IDLE, strobes SHALL be ignored while i_tx_en=0.
REQ-022 Each BYTE bit SHALL shift into a 16-bit word register. The register SHALL clear when a PARITY mode completes.
REQ-023 Parity SHALL be latched at PARITY start:
- PA1 = XOR of word bits 15,13,...,1
- PA0 = XOR of word bits 14,12,...,0, XOR 1
REQ-024 A BYTE mode issued when the word already holds 16 bits SHALL discard the oldest 8 bits (shift-through).
REQ-025 The CRC5 register SHALL initialise to 5'h1F at the start of each CMD_PRE mode.
REQ-026 The CRC5 register SHALL update only on BYTE-mode bits, as follows:
- fb = crc[4] XOR d
- crc = {crc[3:0],0} XOR (fb ? 5'b00101 : 0)
REQ-027 The CRC5 value SHALL be latched at CRC5-mode start.

Reset
REQ-028 During reset, outputs SHALL be o_sda=1, o_sda_pp_od=0 and o_tx_mode_done=0.
REQ-029 During reset, internal state SHALL be FSM=IDLE, bit index=0, word=0 and crc=5'h1F.
REQ-030 Reset asserted mid-mode SHALL take effect immediately and produce no done pulse.
REQ-031 After reset release, the first bit SHALL launch on the first strobe with i_tx_en=1.

Configuration
REQ-032 With DDR_TX_CRC_EN defined, the CRC5 register and the CRC5 mode SHALL be implemented per REQ-025 to REQ-027.
REQ-033 Without DDR_TX_CRC_EN, the CRC logic SHALL be absent and the CRC5 mode SHALL send 1,1,1,1,1 with normal timing and done pulse.

Verification
REQ-034 BYTE, i_tx_byte=8'hA5, 8 strobes -> o_sda 1,0,1,0,0,1,0,1; exactly one done pulse, coincident with the 8th bit.
REQ-035 CMD_PRE, then BYTE 8'h80, BYTE 8'h01, PARITY, with i_tx_en held high -> PARITY bits 1,0; no idle slot between modes.
REQ-036 With DDR_TX_CRC_EN: CMD_PRE, BYTE 8'h00, CRC_TOKEN, CRC5 -> token 1,1,0,0, then CRC 0,1,1,1,1 (5'h0F). Without DDR_TX_CRC_EN -> CRC 1,1,1,1,1.
REQ-037 BYTE 8'hFF, i_tx_en dropped after the 3rd strobe -> o_sda=1 next cycle; no done pulse; FSM in IDLE.
REQ-038 i_sys_rst pulsed low after the 4th bit of BYTE 8'h3C -> o_sda=1 and o_sda_pp_od=0 immediately; no done pulse; crc=5'h1F.
REQ-039 Simultaneous pos and neg strobes during ONE mode -> one bit launched; one done pulse.
